// File: rtl/hires_vmem_writer.sv
// Write-side engine for the hires video RAM: drains a 4-deep CPU write FIFO and runs
// block fill/copy operations, using only phi phases left free by the hires fetch.
module hires_vmem_writer #(
  parameter int ram_width = 16
) (
  input  logic                 clk_dot4x,
  input  logic                 rst_n,
  input  logic                 clk_phi,
  input  logic [15:0]          phi_phase_start,
  input  logic [6:0]           cycle_num,
  input  logic                 wr_req,
  input  logic [ram_width-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  output logic                 wr_ready,
  input  logic                 op_start,
  input  logic                 op_copy,
  input  logic [ram_width-1:0] op_src,
  input  logic [ram_width-1:0] op_dst,
  input  logic [15:0]          op_len,
  input  logic [7:0]           op_value,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [ram_width-1:0] video_mem_addr,
  output logic [7:0]           video_mem_wdata,
  output logic                 video_mem_we,
  output logic                 vmem_active,
  input  logic [7:0]           video_mem_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_CRD  = 3'd2;
  localparam logic [2:0] S_CWR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [ram_width-1:0] addr_one = 1;

  logic [ram_width-1:0] fifo_addr [4];
  logic [7:0]           fifo_data [4];
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           fifo_cnt;
  logic [2:0]           state;
  logic [ram_width-1:0] src, dst;
  logic [15:0]          cnt;
  logic [7:0]           value, cap_data, wr_byte;
  logic                 rd_vld_p0, rd_vld_p1;
  logic                 fw, slot, full, empty, push, pop, fsm_req, fsm_grant;

  always_comb begin
    fw = (cycle_num == 7'd14 && clk_phi) ||
         (cycle_num > 7'd14 && cycle_num < 7'd54) ||
         (cycle_num == 7'd54 && !clk_phi);
    slot = phi_phase_start[10] | phi_phase_start[12] | phi_phase_start[14] |
           (!fw & (phi_phase_start[2] | phi_phase_start[4] |
                   phi_phase_start[6] | phi_phase_start[8]));
    full      = (fifo_cnt == 3'd4);
    empty     = (fifo_cnt == 3'd0);
    push      = wr_req & ~full;
    pop       = slot & ~empty;
    fsm_req   = (state == S_FILL) || (state == S_CRD) || (state == S_CWR);
    fsm_grant = slot & empty & fsm_req;
    // A write slot can land on the very clock the read byte arrives; forward it.
    wr_byte   = rd_vld_p1 ? video_mem_data : cap_data;
  end

  assign wr_ready = ~full;

  always_ff @(posedge clk_dot4x) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
    if (rd_vld_p1) cap_data <= video_mem_data;
    if (state == S_IDLE) begin
      if (op_start) begin
        src   <= op_src;
        dst   <= op_dst;
        cnt   <= op_len;
        value <= op_value;
      end
    end else if (fsm_grant) begin
      case (state)
        S_CRD:   src <= src + addr_one;
        default: begin
          dst <= dst + addr_one;
          cnt <= cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= 2'd0;
      rd_ptr          <= 2'd0;
      fifo_cnt        <= 3'd0;
      state           <= S_IDLE;
      op_busy         <= 1'b0;
      op_done         <= 1'b0;
      rd_vld_p0       <= 1'b0;
      rd_vld_p1       <= 1'b0;
      vmem_active     <= 1'b0;
      video_mem_we    <= 1'b0;
      video_mem_addr  <= '0;
      video_mem_wdata <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: begin end
      endcase

      // RAM port stage: owned for exactly the clock after a used slot
      vmem_active  <= pop | fsm_grant;
      video_mem_we <= pop | (fsm_grant && state != S_CRD);
      if (pop) begin
        video_mem_addr  <= fifo_addr[rd_ptr];
        video_mem_wdata <= fifo_data[rd_ptr];
      end else if (fsm_grant) begin
        video_mem_addr <= (state == S_CRD) ? src : dst;
        if (state == S_FILL) video_mem_wdata <= value;
        else if (state == S_CWR) video_mem_wdata <= wr_byte;
      end

      // Read-return stage: byte arrives two clocks after the read slot
      rd_vld_p0 <= fsm_grant && (state == S_CRD);
      rd_vld_p1 <= rd_vld_p0;

      op_done <= 1'b0;
      case (state)
        S_IDLE: if (op_start) begin
          op_busy <= 1'b1;
          if (op_len == 16'd0) state <= S_DONE;
          else if (op_copy)    state <= S_CRD;
          else                 state <= S_FILL;
        end
        S_FILL: if (fsm_grant && cnt == 16'd1) state <= S_DONE;
        S_CRD:  if (fsm_grant) state <= S_CWR;
        S_CWR:  if (fsm_grant) state <= (cnt == 16'd1) ? S_DONE : S_CRD;
        S_DONE: begin
          op_done <= 1'b1;
          op_busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hires_vmem_writer.sv
// Bench for hires_vmem_writer: a queue-of-accesses reference model checked every cycle,
// directed scenarios with literal RAM expectations, then randomized traffic.
module tb_hires_vmem_writer;
  logic        clk_dot4x = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_phi = 1'b0;
  logic [15:0] phi_phase_start = 16'h0001;
  logic [6:0]  cycle_num = 7'd0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = 16'h0;
  logic [7:0]  wr_data = 8'h0;
  logic        wr_ready;
  logic        op_start = 1'b0, op_copy = 1'b0;
  logic [15:0] op_src = 16'h0, op_dst = 16'h0, op_len = 16'h0;
  logic [7:0]  op_value = 8'h0;
  logic        op_busy, op_done;
  logic [15:0] video_mem_addr;
  logic [7:0]  video_mem_wdata;
  logic        video_mem_we, vmem_active;
  logic [7:0]  video_mem_data;

  hires_vmem_writer #(.ram_width(16)) dut (
    .clk_dot4x(clk_dot4x), .rst_n(rst_n), .clk_phi(clk_phi),
    .phi_phase_start(phi_phase_start), .cycle_num(cycle_num),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .op_start(op_start), .op_copy(op_copy), .op_src(op_src), .op_dst(op_dst),
    .op_len(op_len), .op_value(op_value), .op_busy(op_busy), .op_done(op_done),
    .video_mem_addr(video_mem_addr), .video_mem_wdata(video_mem_wdata),
    .video_mem_we(video_mem_we), .vmem_active(vmem_active),
    .video_mem_data(video_mem_data)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  // Video RAM: writes commit on the edge after we is presented; read data is stable
  // from one clock after the address is presented until the address changes.
  logic [7:0] ram [0:65535] = '{default: 8'h00};
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk_dot4x) begin
    rd_q <= ram[video_mem_addr];
    if (video_mem_we) ram[video_mem_addr] = video_mem_wdata;
  end
  assign video_mem_data = rd_q;

  // Phase generator: 16 phases per phi half, cycle_num advances per full phi
  int phase_cnt = 0, cyc_free = 0, cyc_force = -1;
  bit phases_en = 1'b1;
  always @(posedge clk_dot4x) begin
    #2;
    phase_cnt = (phase_cnt + 1) % 16;
    if (phase_cnt == 0) begin
      clk_phi = ~clk_phi;
      if (!clk_phi) cyc_free = (cyc_free == 62) ? 0 : cyc_free + 1;
    end
    phi_phase_start = phases_en ? (16'h0001 << phase_cnt) : 16'h0000;
    cycle_num = (cyc_force >= 0) ? 7'(cyc_force) : 7'(cyc_free);
  end

  // Reference model
  typedef struct packed { logic rd; logic [15:0] addr; } acc_t;
  acc_t        accq[$];
  logic [15:0] fq_a[$];
  logic [7:0]  fq_d[$];
  logic [7:0]  ref_mem [0:65535] = '{default: 8'h00};
  logic        exp_active = 0, exp_we = 0, exp_ready = 1, exp_busy = 0, exp_done = 0;
  logic [15:0] exp_addr = 0;
  logic [7:0]  exp_data = 0;
  logic        op_active_m = 0, done_next_m = 0, copy_m = 0;
  logic [7:0]  val_m = 0, rd_byte_m = 0;
  logic [15:0] grant_pps = 0;
  acc_t        acc_m;
  logic        act0_m, rdy0_m, fw_m, slot_m;
  int          cn_m;

  always @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      exp_active = 0; exp_we = 0; exp_ready = 1; exp_busy = 0; exp_done = 0;
      exp_addr = 0; exp_data = 0;
      accq.delete(); fq_a.delete(); fq_d.delete();
      op_active_m = 0; done_next_m = 0;
    end else begin
      if (exp_we) ref_mem[exp_addr] = exp_data;
      act0_m = op_active_m;
      rdy0_m = (fq_a.size() < 4);
      exp_active = 0; exp_we = 0; exp_done = 0;
      if (done_next_m) begin
        exp_done = 1; exp_busy = 0; op_active_m = 0; done_next_m = 0;
      end
      cn_m = int'(cycle_num);
      fw_m = (cn_m == 14 && clk_phi) || (cn_m > 14 && cn_m < 54) || (cn_m == 54 && !clk_phi);
      slot_m = phi_phase_start[10] || phi_phase_start[12] || phi_phase_start[14] ||
               (!fw_m && (phi_phase_start[2] || phi_phase_start[4] ||
                          phi_phase_start[6] || phi_phase_start[8]));
      grant_pps = phi_phase_start;
      if (slot_m) begin
        if (fq_a.size() > 0) begin
          exp_active = 1; exp_we = 1;
          exp_addr = fq_a.pop_front(); exp_data = fq_d.pop_front();
        end else if (op_active_m && accq.size() > 0) begin
          acc_m = accq.pop_front();
          exp_active = 1; exp_addr = acc_m.addr;
          if (acc_m.rd) rd_byte_m = ref_mem[acc_m.addr];
          else begin
            exp_we = 1; exp_data = copy_m ? rd_byte_m : val_m;
          end
          if (accq.size() == 0) done_next_m = 1;
        end
      end
      if (wr_req && rdy0_m) begin
        fq_a.push_back(wr_addr); fq_d.push_back(wr_data);
      end
      if (op_start && !act0_m) begin
        op_active_m = 1; exp_busy = 1; copy_m = op_copy; val_m = op_value;
        for (int i = 0; i < int'(op_len); i++) begin
          if (op_copy) accq.push_back('{1'b1, op_src + 16'(i)});
          accq.push_back('{1'b0, op_dst + 16'(i)});
        end
        if (op_len == 16'd0) done_next_m = 1;
      end
      exp_ready = (fq_a.size() < 4);
    end
  end

  // Per-cycle compare
  int n_vec = 0, n_bad = 0, done_cnt = 0, we_cnt = 0;
  logic [15:0] last_we_pps = 0;
  always @(negedge clk_dot4x) begin
    n_vec++;
    if (vmem_active !== exp_active || video_mem_we !== exp_we || video_mem_addr !== exp_addr ||
        video_mem_wdata !== exp_data || wr_ready !== exp_ready || op_busy !== exp_busy ||
        op_done !== exp_done) begin
      n_bad++;
      $display("FAIL port_cycle t=%0t act/we/addr/data/rdy/busy/done got %b/%b/%h/%h/%b/%b/%b expected %b/%b/%h/%h/%b/%b/%b",
               $time, vmem_active, video_mem_we, video_mem_addr, video_mem_wdata, wr_ready, op_busy, op_done,
               exp_active, exp_we, exp_addr, exp_data, exp_ready, exp_busy, exp_done);
    end
    if (op_done === 1'b1) done_cnt++;
    if (video_mem_we === 1'b1) begin
      we_cnt++;
      last_we_pps = grant_pps;
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_dot4x);
    #2;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    int k = 0;
    while (!wr_ready && k < 500) begin tick(); k++; end
    if (k >= 500) check("push_timeout", 1, 0);
    wr_req = 1; wr_addr = a; wr_data = d;
    tick();
    wr_req = 0;
  endtask

  task automatic start_op(input logic cp, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] len, input logic [7:0] v);
    op_start = 1; op_copy = cp; op_src = s; op_dst = d; op_len = len; op_value = v;
    tick();
    op_start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (op_done !== 1'b1 && k < budget) begin tick(); k++; end
    if (k >= budget) check({nm, "_done_timeout"}, 1, 0);
    tick();
  endtask

  logic rdy_seen [6];
  int d0, w0, diffs;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_wr_ready", wr_ready, 1);
    check("rst_active", vmem_active, 0);
    check("rst_busy", op_busy, 0);
    check("rst_addr", video_mem_addr, 0);
    rst_n = 1;
    tick();

    // Single write inside the fetch window
    cyc_force = 30;
    repeat (20) tick();
    push(16'h1234, 8'hAB);
    repeat (60) tick();
    check("single_ram", ram[16'h1234], 8'hAB);
    check("single_phase", int'((last_we_pps & 16'h5400) != 0), 1);

    // FIFO full with no slots available
    phases_en = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      rdy_seen[i] = wr_ready;
      wr_req = 1; wr_addr = 16'h3000 + 16'(i); wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_req = 0;
    check("full_rdy3", rdy_seen[3], 1);
    check("full_rdy4", rdy_seen[4], 0);
    check("full_rdy5", rdy_seen[5], 0);
    phases_en = 1;
    repeat (150) tick();
    for (int i = 0; i < 4; i++) check("full_ram", ram[16'h3000 + 16'(i)], 8'hC0 + i);
    check("full_rej4", ram[16'h3004], 0);
    check("full_rej5", ram[16'h3005], 0);

    // Fill across the address wrap
    cyc_force = -1;
    d0 = done_cnt;
    start_op(1'b0, 16'h0000, 16'hFFFE, 16'd4, 8'h55);
    wait_done("fill", 3000);
    repeat (3) tick();
    check("fill_fffe", ram[16'hFFFE], 8'h55);
    check("fill_ffff", ram[16'hFFFF], 8'h55);
    check("fill_0000", ram[16'h0000], 8'h55);
    check("fill_0001", ram[16'h0001], 8'h55);
    check("fill_done_once", done_cnt - d0, 1);
    check("fill_busy_after", op_busy, 0);

    // Copy outside the fetch window
    cyc_force = 5;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 8'(i + 1));
    repeat (40) tick();
    start_op(1'b1, 16'h0100, 16'h0200, 16'd8, 8'h00);
    wait_done("copy", 3000);
    for (int i = 0; i < 8; i++) check("copy_ram", ram[16'h0200 + 16'(i)], i + 1);

    // Overlapping copy replicates the first byte
    push(16'h0010, 8'h0A);
    push(16'h0011, 8'h0B);
    repeat (20) tick();
    start_op(1'b1, 16'h0010, 16'h0011, 16'd4, 8'h00);
    wait_done("overlap", 3000);
    for (int i = 1; i <= 4; i++) check("overlap_ram", ram[16'h0010 + 16'(i)], 8'h0A);

    // FIFO write preempts a running fill
    cyc_force = 30;
    start_op(1'b0, 16'h0000, 16'h4000, 16'd6, 8'h77);
    repeat (5) tick();
    push(16'h4100, 8'h99);
    wait_done("prio", 3000);
    repeat (10) tick();
    for (int i = 0; i < 6; i++) check("prio_fill", ram[16'h4000 + 16'(i)], 8'h77);
    check("prio_fifo", ram[16'h4100], 8'h99);

    // Zero-length op
    d0 = done_cnt; w0 = we_cnt;
    start_op(1'b0, 16'h0000, 16'h5000, 16'd0, 8'h11);
    wait_done("len0", 20);
    check("len0_done", done_cnt - d0, 1);
    check("len0_no_we", we_cnt - w0, 0);

    // Reset mid-copy
    cyc_force = 5;
    d0 = done_cnt;
    start_op(1'b1, 16'h0500, 16'h0600, 16'd20, 8'h00);
    repeat (30) tick();
    rst_n = 0;
    #1;
    check("rstmid_active", vmem_active, 0);
    check("rstmid_we", video_mem_we, 0);
    check("rstmid_addr", video_mem_addr, 0);
    check("rstmid_wdata", video_mem_wdata, 0);
    check("rstmid_busy", op_busy, 0);
    check("rstmid_ready", wr_ready, 1);
    repeat (3) tick();
    rst_n = 1;
    repeat (20) tick();
    check("rstmid_no_done", done_cnt - d0, 0);

    // Randomized traffic
    cyc_force = -1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      wr_req = (r < 25);
      wr_addr = 16'h0800 + 16'($urandom_range(0, 63));
      wr_data = 8'($urandom);
      op_start = (r >= 95);
      op_copy = 1'($urandom_range(0, 1));
      op_src = 16'h0800 + 16'($urandom_range(0, 63));
      op_dst = 16'h0800 + 16'($urandom_range(0, 63));
      op_len = 16'($urandom_range(0, 12));
      op_value = 8'($urandom);
      tick();
    end
    wr_req = 0; op_start = 0;
    begin
      int k = 0;
      tick(); tick();
      while (op_busy === 1'b1 && k < 4000) begin tick(); k++; end
      if (k >= 4000) check("rand_busy_timeout", 1, 0);
    end
    repeat (200) tick();
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) diffs++;
    check("ram_vs_model", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
